filter_step_sequencer: RTL

//  Sequences a stimulus-driven filter under test: flushes the filter via its reset, then steps its

---
 rtl/filter_step_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/filter_step_sequencer.sv
// filter_step_sequencer
//   Drives a filter under test through a programmed staircase of input levels.
//   The filter is first flushed by holding filt_rst high for FLUSH_CYC cycles.
//   Each table entry is then driven on v_in for its dwell count, and v_out is
//   monitored against the level being driven. A step is marked settled once the
//   output has stayed within TOL of the level for SETTLE_CNT consecutive cycles.
//
// Optional feature macro: FILT_SEQ_LOOP_EN
//   When defined, the sequence wraps from the last step back to step 0. There is
//   no flush and no done pulse at the wrap, and the settled flags are cleared.
//   The sequence then runs until abort or rst.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   cfg_we        table write strobe, accepted only while busy is low
//   cfg_addr      table index; indices >= N_STEPS are ignored
//   cfg_level     signed level for the entry
//   cfg_dwell     dwell cycles for the entry; a value of 0 is stored as 1
//   start         begins a run when the sequencer is idle (level-sensitive)
//   abort         ends a flush or drive and returns to idle; no done pulse
//   v_out         filter output being monitored
//   v_in          filter input drive; zero whenever no step is being driven
//   filt_rst      reset to the filter; high at reset and during flush
//   busy          high from the first flush cycle through the last drive cycle
//   done          one-cycle pulse after a normal single-pass completion
//   step_idx      index of the step currently driven
//   settled       per-step settle flags, sticky until the next flush
//
// Handshake: there is no back-pressure. start and cfg_we are sampled on every
// rising edge. start is acted on only in idle, and cfg_we only while busy is low.
// Every output is a register, updated on the edge that enters the new state.
module filter_step_sequencer #(
  parameter int WIDTH      = 18,
  parameter int N_STEPS    = 4,
  parameter int DWELL_W    = 16,
  parameter int FLUSH_CYC  = 4,
  parameter int TOL        = 164,
  parameter int SETTLE_CNT = 8,
  localparam int AW        = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [AW-1:0]             cfg_addr,
  input  logic signed [WIDTH-1:0]   cfg_level,
  input  logic [DWELL_W-1:0]        cfg_dwell,
  input  logic                      start,
  input  logic                      abort,
  input  logic signed [WIDTH-1:0]   v_out,
  output logic signed [WIDTH-1:0]   v_in,
  output logic                      filt_rst,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             step_idx,
  output logic [N_STEPS-1:0]        settled
);

  localparam int BW = $clog2(SETTLE_CNT + 1);
  localparam logic [BW-1:0]      SET_V   = BW'(SETTLE_CNT);
  localparam logic [WIDTH:0]     TOL_V   = (WIDTH + 1)'(TOL);
  localparam logic [AW-1:0]      LAST    = AW'(N_STEPS - 1);
  localparam logic [DWELL_W-1:0] FLUSH_V = DWELL_W'(FLUSH_CYC);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_DRIVE, S_DONE} state_t;

  state_t                    state_q, state_n;
  logic [AW-1:0]             step_n;
  logic [DWELL_W-1:0]        cnt_q, cnt_n;
  logic [BW-1:0]             band_q, band_n, band_inc;
  logic [N_STEPS-1:0]        settled_n;
  logic signed [WIDTH-1:0]   v_in_n;
  logic                      load, wrap, in_band, addr_ok;
  logic signed [WIDTH:0]     diff;
  logic [WIDTH:0]            abs_diff;

  logic signed [WIDTH-1:0]   level_tab [N_STEPS];
  logic [DWELL_W-1:0]        dwell_tab [N_STEPS];

  // When N_STEPS is a power of two, every address is in range.
  generate
    if ((2 ** AW) == N_STEPS) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_cmp
      assign addr_ok = (32'(cfg_addr) < N_STEPS);
    end
  endgenerate

  // Table writes. A dwell of 0 is stored as 1, so the sequencer never sees a
  // zero-length step.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_STEPS; i++) begin
        level_tab[i] <= '0;
        dwell_tab[i] <= DWELL_W'(1);
      end
    end else if (cfg_we && !busy && addr_ok) begin
      level_tab[cfg_addr] <= cfg_level;
      dwell_tab[cfg_addr] <= (cfg_dwell == '0) ? DWELL_W'(1) : cfg_dwell;
    end
  end

  // Next-state logic. cnt_q holds the cycles remaining in the current flush or
  // step, including the present cycle.
  always_comb begin
    state_n = state_q;
    step_n  = step_idx;
    cnt_n   = cnt_q;
    load    = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n = S_FLUSH;
          cnt_n   = FLUSH_V;
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (cnt_q <= DWELL_W'(1)) begin
          state_n = S_DRIVE;
          step_n  = '0;
          load    = 1'b1;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_n = S_IDLE;
        end else if (cnt_q <= DWELL_W'(1)) begin
          if (step_idx == LAST) begin
`ifdef FILT_SEQ_LOOP_EN
            step_n = '0;
            load   = 1'b1;
            wrap   = 1'b1;
`else
            state_n = S_DONE;
`endif
          end else begin
            step_n = step_idx + 1'b1;
            load   = 1'b1;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_DONE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (load) cnt_n = dwell_tab[step_n];
    if (state_n == S_IDLE) step_n = '0;
  end

  // Settle monitor. The difference is taken one bit wider than the operands,
  // so the magnitude cannot overflow.
  always_comb begin
    diff      = $signed({v_out[WIDTH-1], v_out}) - $signed({v_in[WIDTH-1], v_in});
    abs_diff  = diff[WIDTH] ? (WIDTH + 1)'(-diff) : (WIDTH + 1)'(diff);
    in_band   = (abs_diff <= TOL_V);
    band_inc  = (band_q == SET_V) ? band_q : band_q + 1'b1;
    band_n    = band_q;
    settled_n = settled;
    if (state_q == S_DRIVE) begin
      band_n = in_band ? band_inc : '0;
      if (in_band && (band_inc == SET_V)) settled_n[step_idx] = 1'b1;
    end
    // The count restarts at every step entry. The last cycle of a step still
    // counts toward that step's flag.
    if (load) band_n = '0;
    if (wrap) settled_n = '0;
    if ((state_q == S_IDLE) && (state_n == S_FLUSH)) settled_n = '0;
  end

  assign v_in_n = (state_n == S_DRIVE) ? level_tab[step_n] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      step_idx <= '0;
      cnt_q    <= '0;
      band_q   <= '0;
      settled  <= '0;
      v_in     <= '0;
      filt_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_n;
      step_idx <= step_n;
      cnt_q    <= cnt_n;
      band_q   <= band_n;
      settled  <= settled_n;
      v_in     <= v_in_n;
      filt_rst <= (state_n == S_FLUSH);
      busy     <= (state_n == S_FLUSH) || (state_n == S_DRIVE);
      done     <= (state_n == S_DONE);
    end
  end

endmodule
